// File: rtl/core_icache.sv
// Direct-mapped read-only instruction cache serving s1 fetches, refilling whole
// lines from a single-outstanding word memory port; supports a whole-cache flush.
package core_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
  } mmu_instr_req_s;

  typedef struct packed {
    logic [31:0] instr;
    logic        ready;
    logic        illegal;
  } mmu_instr_rsp_s;
endpackage

module core_icache
  import core_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  mmu_instr_req_s req,
  output mmu_instr_rsp_s rsp,
  input  logic           flush,
  output logic           mem_req_valid,
  output logic [31:0]    mem_req_addr,
  input  logic           mem_rsp_ready,
  input  logic [31:0]    mem_rsp_data,
  input  logic           mem_rsp_illegal
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESP} state_e;

  state_e state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES][LINE_WORDS];

  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [OFF_W-1:0] word_q;
  logic [OFF_W-1:0] cnt_q;
  logic             fault_q;
  logic             flush_seen_q;

  logic        rsp_ready_q, rsp_ready_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic [31:0] rsp_instr_q, rsp_instr_d;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic [31:0] mem_req_addr_q, mem_req_addr_d;

  logic [OFF_W-1:0] req_word;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic accept, misaligned, hit, miss_start;
  logic last_word, fill_step, fill_done, fault_now;

  assign req_word = req.addr[2 +: OFF_W];
  assign req_idx  = req.addr[2+OFF_W +: IDX_W];
  assign req_tag  = req.addr[31 -: TAG_W];

  // A held request is not re-accepted in the cycle its response is visible.
  assign accept     = (state_q == S_IDLE) && req.valid && !rsp_ready_q;
  assign misaligned = (req.addr[1:0] != 2'b00);
  assign hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;
  assign miss_start = accept && !misaligned && !hit;

  assign last_word = (cnt_q == OFF_W'(LINE_WORDS - 1));
  assign fill_step = (state_q == S_FILL) && mem_rsp_ready;
  assign fill_done = fill_step && last_word;
  assign fault_now = fault_q | mem_rsp_illegal;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      rsp_ready_q     <= 1'b0;
      rsp_illegal_q   <= 1'b0;
      rsp_instr_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      rsp_ready_q     <= rsp_ready_d;
      rsp_illegal_q   <= rsp_illegal_d;
      rsp_instr_q     <= rsp_instr_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (miss_start) state_d = S_FILL;
      S_FILL:  if (fill_done)  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; response data holds while not ready.
  always_comb begin
    rsp_ready_d     = 1'b0;
    rsp_illegal_d   = rsp_illegal_q;
    rsp_instr_d     = rsp_instr_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            rsp_ready_d   = 1'b1;
            rsp_illegal_d = 1'b1;
            rsp_instr_d   = '0;
          end else if (hit) begin
            rsp_ready_d   = 1'b1;
            rsp_illegal_d = 1'b0;
            rsp_instr_d   = data_mem[req_idx][req_word];
          end else begin
            mem_req_valid_d = 1'b1;
            mem_req_addr_d  = {req.addr[31:2+OFF_W], (OFF_W+2)'(0)};
          end
        end
      end
      S_FILL: begin
        if (fill_step) begin
          if (last_word) begin
            mem_req_valid_d = 1'b0;
            rsp_ready_d     = 1'b1;
            rsp_illegal_d   = fault_now;
            // The requested word may be the one arriving this cycle.
            if (fault_now)            rsp_instr_d = '0;
            else if (word_q == cnt_q) rsp_instr_d = mem_rsp_data;
            else                      rsp_instr_d = data_mem[idx_q][word_q];
          end else begin
            mem_req_addr_d = mem_req_addr_q + 32'd4;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q        <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      cnt_q        <= '0;
      fault_q      <= 1'b0;
      flush_seen_q <= 1'b0;
    end else if (miss_start) begin
      tag_q        <= req_tag;
      idx_q        <= req_idx;
      word_q       <= req_word;
      cnt_q        <= '0;
      fault_q      <= 1'b0;
      flush_seen_q <= 1'b0;
    end else if (state_q == S_FILL) begin
      if (flush) flush_seen_q <= 1'b1;
      if (mem_rsp_ready) begin
        cnt_q   <= cnt_q + OFF_W'(1);
        fault_q <= fault_now;
      end
    end
  end

  // Flush wins over a completing fill; a faulted or flushed fill stays invalid.
  always_ff @(posedge clk) begin
    if (!rst_n)         valid_q <= '0;
    else if (flush)     valid_q <= '0;
    else if (fill_done) valid_q[idx_q] <= !fault_now && !flush_seen_q;
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone make them
  // meaningful, which keeps them mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (rst_n && fill_step) begin
      data_mem[idx_q][cnt_q] <= mem_rsp_data;
      if (last_word) tag_mem[idx_q] <= tag_q;
    end
  end

  assign rsp.ready     = rsp_ready_q;
  assign rsp.illegal   = rsp_illegal_q;
  assign rsp.instr     = rsp_instr_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;

endmodule
